// File: rtl/alu_rs.sv
`default_nettype none
// ============================================================================
//  Module      : alu_rs
//  Description : Eight-entry reservation station in front of the integer ALU.
//                Dispatches into the lowest free slot, wakes operands from two
//                result buses, and issues the lowest ready slot each cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_rs (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        clear,
    input  logic        in_valid,
    input  logic [5:0]  in_opcode,
    input  logic [3:0]  in_rob_id,
    input  logic        in_qj_valid,
    input  logic        in_qk_valid,
    input  logic [3:0]  in_qj,
    input  logic [3:0]  in_qk,
    input  logic [31:0] in_vj,
    input  logic [31:0] in_vk,
    input  logic [31:0] in_imm,
    input  logic [31:0] in_pc,
    output logic        full,
    input  logic        cdb0_valid,
    input  logic [3:0]  cdb0_rob_id,
    input  logic [31:0] cdb0_value,
    input  logic        cdb1_valid,
    input  logic [3:0]  cdb1_rob_id,
    input  logic [31:0] cdb1_value,
    output logic        alu_en,
    output logic [3:0]  alu_rob_id,
    output logic [5:0]  alu_opcode,
    output logic [31:0] alu_rs1,
    output logic [31:0] alu_rs2,
    output logic [31:0] alu_imm,
    output logic [31:0] alu_pc
);

    localparam int c_DEPTH = 8;
    localparam int c_IDX_W = 3;

    // Per-entry state exported from the generate loop for selection/muxing.
    logic [c_DEPTH-1:0] w_busy;
    logic [c_DEPTH-1:0] w_ready;
    logic [c_DEPTH-1:0] w_iss_oh;
    logic [c_DEPTH-1:0] w_alloc_oh;
    logic [c_IDX_W-1:0] w_iss_idx;
    logic               w_iss_any;
    logic               w_disp;

    logic [5:0]         w_e_opcode [c_DEPTH];
    logic [3:0]         w_e_rob_id [c_DEPTH];
    logic [31:0]        w_e_vj     [c_DEPTH];
    logic [31:0]        w_e_vk     [c_DEPTH];
    logic [31:0]        w_e_imm    [c_DEPTH];
    logic [31:0]        w_e_pc     [c_DEPTH];

    // Incoming operands after same-cycle CDB bypass.
    logic               w_in_qj_valid;
    logic               w_in_qk_valid;
    logic [31:0]        w_in_vj;
    logic [31:0]        w_in_vk;

    // True when either result bus carries the given tag this cycle.
    function automatic logic f_cdb_hit(input logic [3:0] tag);
        return (cdb0_valid && (cdb0_rob_id == tag)) ||
               (cdb1_valid && (cdb1_rob_id == tag));
    endfunction

    // Value for a tag; cdb0 wins when both buses carry the same tag.
    function automatic logic [31:0] f_cdb_val(input logic [3:0] tag);
        return (cdb0_valid && (cdb0_rob_id == tag)) ? cdb0_value : cdb1_value;
    endfunction

    assign full      = &w_busy;
    assign w_iss_any = |w_ready;
    assign w_disp    = in_valid && !full && !clear;

    // Lowest set bit of the ready vector, lowest clear bit of the busy vector.
    // Busy is sampled at the start of the cycle, so a slot freed by this
    // cycle's issue cannot be reallocated until the following cycle.
    assign w_iss_oh   = w_ready & (~w_ready + 8'd1);
    assign w_alloc_oh = ~w_busy & (w_busy + 8'd1);

    // One-hot to binary for the fixed depth of eight.
    assign w_iss_idx[0] = w_iss_oh[1] | w_iss_oh[3] | w_iss_oh[5] | w_iss_oh[7];
    assign w_iss_idx[1] = w_iss_oh[2] | w_iss_oh[3] | w_iss_oh[6] | w_iss_oh[7];
    assign w_iss_idx[2] = |w_iss_oh[7:4];

    // Resolve dispatch operands against the result buses of the same cycle.
    always_comb begin
        w_in_qj_valid = in_qj_valid;
        w_in_qk_valid = in_qk_valid;
        w_in_vj       = in_vj;
        w_in_vk       = in_vk;
        if (in_qj_valid && f_cdb_hit(in_qj)) begin
            w_in_qj_valid = 1'b0;
            w_in_vj       = f_cdb_val(in_qj);
        end
        if (in_qk_valid && f_cdb_hit(in_qk)) begin
            w_in_qk_valid = 1'b0;
            w_in_vk       = f_cdb_val(in_qk);
        end
    end

    generate
        for (genvar gi = 0; gi < c_DEPTH; gi++) begin : g_entry
            logic        r_busy;
            logic [5:0]  r_opcode;
            logic [3:0]  r_rob_id;
            logic        r_qj_valid;
            logic [3:0]  r_qj;
            logic [31:0] r_vj;
            logic        r_qk_valid;
            logic [3:0]  r_qk;
            logic [31:0] r_vk;
            logic [31:0] r_imm;
            logic [31:0] r_pc;

            // Entry update: flush, allocate, or wake-up and release on issue.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_busy     <= 1'b0;
                    r_opcode   <= '0;
                    r_rob_id   <= '0;
                    r_qj_valid <= 1'b0;
                    r_qj       <= '0;
                    r_vj       <= '0;
                    r_qk_valid <= 1'b0;
                    r_qk       <= '0;
                    r_vk       <= '0;
                    r_imm      <= '0;
                    r_pc       <= '0;
                end else if (rdy) begin
                    if (clear) begin
                        r_busy <= 1'b0;
                    end else if (w_disp && w_alloc_oh[gi]) begin
                        r_busy     <= 1'b1;
                        r_opcode   <= in_opcode;
                        r_rob_id   <= in_rob_id;
                        r_qj_valid <= w_in_qj_valid;
                        r_qj       <= in_qj;
                        r_vj       <= w_in_vj;
                        r_qk_valid <= w_in_qk_valid;
                        r_qk       <= in_qk;
                        r_vk       <= w_in_vk;
                        r_imm      <= in_imm;
                        r_pc       <= in_pc;
                    end else begin
                        if (w_iss_oh[gi]) begin
                            r_busy <= 1'b0;
                        end
                        if (r_busy && r_qj_valid && f_cdb_hit(r_qj)) begin
                            r_qj_valid <= 1'b0;
                            r_vj       <= f_cdb_val(r_qj);
                        end
                        if (r_busy && r_qk_valid && f_cdb_hit(r_qk)) begin
                            r_qk_valid <= 1'b0;
                            r_vk       <= f_cdb_val(r_qk);
                        end
                    end
                end
            end

            // Readiness looks at registered state only, adding one cycle after
            // dispatch or wake-up before the entry can be selected.
            assign w_busy[gi]     = r_busy;
            assign w_ready[gi]    = r_busy && !r_qj_valid && !r_qk_valid;
            assign w_e_opcode[gi] = r_opcode;
            assign w_e_rob_id[gi] = r_rob_id;
            assign w_e_vj[gi]     = r_vj;
            assign w_e_vk[gi]     = r_vk;
            assign w_e_imm[gi]    = r_imm;
            assign w_e_pc[gi]     = r_pc;
        end
    endgenerate

    // Issue register: strobe plus payload of the selected entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alu_en     <= 1'b0;
            alu_rob_id <= '0;
            alu_opcode <= '0;
            alu_rs1    <= '0;
            alu_rs2    <= '0;
            alu_imm    <= '0;
            alu_pc     <= '0;
        end else if (rdy) begin
            if (clear) begin
                alu_en <= 1'b0;
            end else begin
                alu_en <= w_iss_any;
                if (w_iss_any) begin
                    alu_rob_id <= w_e_rob_id[w_iss_idx];
                    alu_opcode <= w_e_opcode[w_iss_idx];
                    alu_rs1    <= w_e_vj[w_iss_idx];
                    alu_rs2    <= w_e_vk[w_iss_idx];
                    alu_imm    <= w_e_imm[w_iss_idx];
                    alu_pc     <= w_e_pc[w_iss_idx];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_rs.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_rs
//  Description : Directed bench for alu_rs with an issue scoreboard.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_rs;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        clear;
    logic        in_valid;
    logic [5:0]  in_opcode;
    logic [3:0]  in_rob_id;
    logic        in_qj_valid;
    logic        in_qk_valid;
    logic [3:0]  in_qj;
    logic [3:0]  in_qk;
    logic [31:0] in_vj;
    logic [31:0] in_vk;
    logic [31:0] in_imm;
    logic [31:0] in_pc;
    logic        full;
    logic        cdb0_valid;
    logic [3:0]  cdb0_rob_id;
    logic [31:0] cdb0_value;
    logic        cdb1_valid;
    logic [3:0]  cdb1_rob_id;
    logic [31:0] cdb1_value;
    logic        alu_en;
    logic [3:0]  alu_rob_id;
    logic [5:0]  alu_opcode;
    logic [31:0] alu_rs1;
    logic [31:0] alu_rs2;
    logic [31:0] alu_imm;
    logic [31:0] alu_pc;

    alu_rs dut (
        .clk         (clk),
        .rst         (rst),
        .rdy         (rdy),
        .clear       (clear),
        .in_valid    (in_valid),
        .in_opcode   (in_opcode),
        .in_rob_id   (in_rob_id),
        .in_qj_valid (in_qj_valid),
        .in_qk_valid (in_qk_valid),
        .in_qj       (in_qj),
        .in_qk       (in_qk),
        .in_vj       (in_vj),
        .in_vk       (in_vk),
        .in_imm      (in_imm),
        .in_pc       (in_pc),
        .full        (full),
        .cdb0_valid  (cdb0_valid),
        .cdb0_rob_id (cdb0_rob_id),
        .cdb0_value  (cdb0_value),
        .cdb1_valid  (cdb1_valid),
        .cdb1_rob_id (cdb1_rob_id),
        .cdb1_value  (cdb1_value),
        .alu_en      (alu_en),
        .alu_rob_id  (alu_rob_id),
        .alu_opcode  (alu_opcode),
        .alu_rs1     (alu_rs1),
        .alu_rs2     (alu_rs2),
        .alu_imm     (alu_imm),
        .alu_pc      (alu_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  rob;
        logic [5:0]  op;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [31:0] pc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_on = 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample 1 time unit after the edge and score any issue.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (mon_on && alu_en === 1'b1) begin
            if (q.size() == 0) begin
                chk("unexpected_issue", 32'(alu_en), 32'd0);
            end else begin
                e = q.pop_front();
                chk("issue_rob_id", 32'(alu_rob_id), 32'(e.rob));
                chk("issue_opcode", 32'(alu_opcode), 32'(e.op));
                chk("issue_rs1",    alu_rs1,         e.rs1);
                chk("issue_rs2",    alu_rs2,         e.rs2);
                chk("issue_imm",    alu_imm,         e.imm);
                chk("issue_pc",     alu_pc,          e.pc);
            end
        end
    endtask

    task automatic idle();
        in_valid    = 1'b0;
        in_qj_valid = 1'b0;
        in_qk_valid = 1'b0;
        cdb0_valid  = 1'b0;
        cdb1_valid  = 1'b0;
        clear       = 1'b0;
    endtask

    task automatic disp(input logic [5:0] op, input logic [3:0] rob,
                        input logic qjv, input logic [3:0] qj, input logic [31:0] vj,
                        input logic qkv, input logic [3:0] qk, input logic [31:0] vk,
                        input logic [31:0] imm, input logic [31:0] pc);
        in_valid    = 1'b1;
        in_opcode   = op;
        in_rob_id   = rob;
        in_qj_valid = qjv;
        in_qj       = qj;
        in_vj       = vj;
        in_qk_valid = qkv;
        in_qk       = qk;
        in_vk       = vk;
        in_imm      = imm;
        in_pc       = pc;
    endtask

    task automatic expect_issue(input logic [3:0] rob, input logic [5:0] op,
                                input logic [31:0] rs1, input logic [31:0] rs2,
                                input logic [31:0] imm, input logic [31:0] pc);
        exp_t e;
        e.rob = rob; e.op = op; e.rs1 = rs1; e.rs2 = rs2; e.imm = imm; e.pc = pc;
        q.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0; rdy = 1'b1;
        in_opcode = '0; in_rob_id = '0; in_qj = '0; in_qk = '0;
        in_vj = '0; in_vk = '0; in_imm = '0; in_pc = '0;
        cdb0_rob_id = '0; cdb0_value = '0; cdb1_rob_id = '0; cdb1_value = '0;
        idle();

        // Reset state.
        #2;
        chk("reset_alu_en", 32'(alu_en), 32'd0);
        chk("reset_full", 32'(full), 32'd0);
        chk("reset_rs1", alu_rs1, 32'd0);
        chk("reset_rob_id", 32'(alu_rob_id), 32'd0);
        #10;
        rst = 1'b1;

        // Ready dispatch issues exactly one cycle later.
        disp(6'h01, 4'd3, 1'b0, 4'd0, 32'd5, 1'b0, 4'd0, 32'd7, 32'h10, 32'h1000);
        tick();
        idle();
        chk("ready_not_same_edge", 32'(alu_en), 32'd0);
        expect_issue(4'd3, 6'h01, 32'd5, 32'd7, 32'h10, 32'h1000);
        tick();
        chk("ready_issue_en", 32'(alu_en), 32'd1);
        tick();
        chk("ready_en_drops", 32'(alu_en), 32'd0);

        // Wake-up of a pending j operand from cdb1.
        disp(6'h02, 4'd4, 1'b1, 4'd2, 32'hDEAD, 1'b0, 4'd0, 32'd9, 32'h20, 32'h2000);
        tick();
        idle();
        tick();
        chk("wake_pending_no_issue", 32'(alu_en), 32'd0);
        cdb1_valid = 1'b1; cdb1_rob_id = 4'd2; cdb1_value = 32'h100;
        tick();
        idle();
        chk("wake_latency", 32'(alu_en), 32'd0);
        expect_issue(4'd4, 6'h02, 32'h100, 32'd9, 32'h20, 32'h2000);
        tick();
        chk("wake_issue_en", 32'(alu_en), 32'd1);
        tick();
        chk("wake_en_drops", 32'(alu_en), 32'd0);

        // Dispatch bypass with both buses on the same tag: cdb0 wins.
        disp(6'h03, 4'd5, 1'b0, 4'd0, 32'h33, 1'b1, 4'd6, 32'hBAD, 32'h30, 32'h3000);
        cdb0_valid = 1'b1; cdb0_rob_id = 4'd6; cdb0_value = 32'hA;
        cdb1_valid = 1'b1; cdb1_rob_id = 4'd6; cdb1_value = 32'hB;
        tick();
        idle();
        expect_issue(4'd5, 6'h03, 32'h33, 32'hA, 32'h30, 32'h3000);
        tick();
        chk("bypass_issue_en", 32'(alu_en), 32'd1);
        tick();
        chk("bypass_en_drops", 32'(alu_en), 32'd0);

        // Fill all eight entries pending on tag 9.
        for (int i = 0; i < 8; i++) begin
            disp(6'h04, 4'(i), 1'b1, 4'd9, 32'd0, 1'b0, 4'd0, 32'(i * 16),
                 32'(i), 32'h4000 + 32'(i * 4));
            tick();
            chk("fill_full", 32'(full), (i == 7) ? 32'd1 : 32'd0);
        end
        // A ninth dispatch while full must be dropped.
        disp(6'h3F, 4'd15, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0, 32'd1, 32'd0, 32'hF000);
        tick();
        idle();
        chk("full_hold", 32'(full), 32'd1);
        chk("full_no_issue", 32'(alu_en), 32'd0);
        cdb0_valid = 1'b1; cdb0_rob_id = 4'd9; cdb0_value = 32'h999;
        tick();
        idle();
        chk("full_wake_latency", 32'(alu_en), 32'd0);
        for (int i = 0; i < 8; i++) begin
            expect_issue(4'(i), 6'h04, 32'h999, 32'(i * 16), 32'(i), 32'h4000 + 32'(i * 4));
        end
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("order_issue_en", 32'(alu_en), 32'd1);
            if (k == 0) chk("full_drops", 32'(full), 32'd0);
        end
        tick();
        chk("drain_en_drops", 32'(alu_en), 32'd0);
        chk("drain_queue_empty", 32'(q.size()), 32'd0);

        // Flush on the cycle of the first issue.
        for (int i = 1; i <= 3; i++) begin
            disp(6'h05, 4'(i), 1'b1, 4'd5, 32'd0, 1'b0, 4'd0, 32'(i), 32'h50, 32'h5000 + 32'(i));
            tick();
        end
        idle();
        cdb1_valid = 1'b1; cdb1_rob_id = 4'd5; cdb1_value = 32'h55;
        tick();
        idle();
        expect_issue(4'd1, 6'h05, 32'h55, 32'd1, 32'h50, 32'h5001);
        tick();
        chk("flush_first_issue", 32'(alu_en), 32'd1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("flush_en", 32'(alu_en), 32'd0);
        chk("flush_full", 32'(full), 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("flush_no_issue", 32'(alu_en), 32'd0);
        end

        // Stall with rdy=0, then reset mid-stall.
        disp(6'h06, 4'd10, 1'b0, 4'd0, 32'hA0, 1'b0, 4'd0, 32'hA1, 32'h60, 32'h6000);
        tick();
        disp(6'h06, 4'd11, 1'b0, 4'd0, 32'hB0, 1'b0, 4'd0, 32'hB1, 32'h61, 32'h6004);
        expect_issue(4'd10, 6'h06, 32'hA0, 32'hA1, 32'h60, 32'h6000);
        tick();
        chk("stall_pre_issue", 32'(alu_en), 32'd1);
        idle();
        rdy = 1'b0;
        mon_on = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stall_en_held", 32'(alu_en), 32'd1);
            chk("stall_rob_held", 32'(alu_rob_id), 32'd10);
        end
        #3;
        rst = 1'b0;
        #1;
        chk("async_reset_en", 32'(alu_en), 32'd0);
        chk("async_reset_rob", 32'(alu_rob_id), 32'd0);
        chk("async_reset_rs1", alu_rs1, 32'd0);
        chk("async_reset_full", 32'(full), 32'd0);
        #2;
        rst = 1'b1;
        rdy = 1'b1;
        mon_on = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("post_reset_no_issue", 32'(alu_en), 32'd0);
        end
        chk("final_queue_empty", 32'(q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_rs.md
ALU_RS -- requirements
Module: alu_rs

Interface
REQ-001 The block SHALL have no parameters; depth is fixed at 8 entries, the ROB tag is 4 bits and the data is 32 bits.
REQ-002 clk  in  1  the single clock; all state updates on its rising edge.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 rdy  in  1  global enable; when 0, all state and outputs hold.
REQ-005 clear  in  1  misprediction flush.
REQ-006 in_valid  in  1  dispatch request from decoder.
REQ-007 in_opcode  in  6  internal opcode, as consumed by the ALU.
REQ-008 in_rob_id  in  4  destination ROB tag.
REQ-009 in_qj_valid / in_qk_valid  in  1 each  operand j/k still pending.
REQ-010 in_qj / in_qk  in  4 each  producer ROB tag when pending.
REQ-011 in_vj / in_vk  in  32 each  operand value when not pending.
REQ-012 in_imm, in_pc  in  32 each  immediate and instruction PC.
REQ-013 full  out  1  all 8 entries busy (combinational from the busy bits).
REQ-014 cdb0_valid, cdb0_rob_id[4], cdb0_value[32]  in  ALU result broadcast.
REQ-015 cdb1_valid, cdb1_rob_id[4], cdb1_value[32]  in  load-unit result broadcast.
REQ-016 alu_en  out  1  registered issue strobe to the ALU work_en input.
REQ-017 alu_rob_id[4], alu_opcode[6], alu_rs1[32], alu_rs2[32], alu_imm[32], alu_pc[32]  out  registered issue payload.

Function
REQ-018 Each entry SHALL hold: busy, opcode, rob_id, qj_valid, qj, vj, qk_valid, qk, vk, imm, pc.
REQ-019 Dispatch: when in_valid=1, full=0, clear=0 and rdy=1, the block SHALL write the lowest-index entry whose busy bit was 0 at the start of the cycle, and set busy=1.
REQ-020 A dispatch with in_valid=1 while full=1 SHALL be ignored; upstream owns the stall.
REQ-021 Wake-up: on each enabled edge, every busy entry with qj_valid=1 and qj equal to a valid CDB tag SHALL capture that CDB value into vj and clear qj_valid; the same rule applies to qk.
REQ-022 Dispatch bypass: an incoming operand whose pending tag matches a valid CDB tag in the same cycle SHALL be stored as ready, with the CDB value.
REQ-023 If both CDBs carry the same tag, cdb0 SHALL take priority.
REQ-024 Ready: an entry is ready when busy=1, qj_valid=0 and qk_valid=0, evaluated on registered state only.
REQ-025 Consequences of REQ-024: an entry dispatched or woken in cycle N is issuable no earlier than cycle N+1.
REQ-026 Issue: each enabled cycle, the lowest-index ready entry SHALL be selected.
REQ-027 At the selection edge, the issue payload is registered, alu_en goes to 1 and the entry's busy bit clears.
REQ-028 Issue latency SHALL be exactly 1 cycle from the entry becoming ready.
REQ-029 Operand mapping on issue: alu_rs1=vj, alu_rs2=vk, alu_imm=imm, alu_pc=pc.
REQ-030 If no entry is ready, alu_en SHALL be 0 on the next edge; the payload registers may hold stale values.
REQ-031 An entry freed by issue SHALL NOT be reallocated in the same cycle (see REQ-019).
REQ-032 Throughput: at most one dispatch and one issue per cycle.
REQ-033 Dispatch and issue SHALL proceed simultaneously when full=0.
REQ-034 Clear: when clear=1 and rdy=1, all busy bits SHALL be 0 after the edge and alu_en SHALL be 0.
REQ-035 While clear=1, dispatch and CDB inputs in that cycle are discarded.
REQ-036 rdy=0 SHALL freeze all entries and outputs, including alu_en; CDB and dispatch inputs are not captured.

Reset
REQ-037 While rst=0, asynchronously: all busy=0, alu_en=0, and all alu_* payload outputs=0; consequently full=0.
REQ-038 A reset asserted mid-operation SHALL discard all entries; no issue occurs in the cycle after rst deasserts unless an entry is dispatched.

Verification
REQ-039 Ready dispatch: dispatch opcode ADD, rob 3, vj=5, vk=7, both ready, at cycle 0 -> alu_en=1 at cycle 1 with alu_rob_id=3, rs1=5, rs2=7; at cycle 2, alu_en=0.
REQ-040 Wake-up: dispatch rob 4 with qj=2 pending; cdb1 broadcasts tag 2, value 0x100 at cycle 2 -> issue at cycle 3 with alu_rs1=0x100.
REQ-041 Bypass and priority: dispatch with qk=6 while cdb0 and cdb1 both carry tag 6 (values 0xA, 0xB) -> the stored entry is ready and issues with rs2=0xA.
REQ-042 Full and ordering: fill 8 entries, all pending on tag 9 -> full=1 and a 9th in_valid is ignored; broadcast tag 9 -> entries issue in index order 0..7 over 8 consecutive cycles, and full drops after the first issue.
REQ-043 Flush: fill 3 ready entries, assert clear on the cycle of the first issue -> alu_en=0 on the next edge, full=0, and no later issues.
REQ-044 Reset and stall: hold rdy=0 with a ready entry -> no issue and alu_en held; pull rst low mid-stall -> alu_en=0 immediately, and no issue after release.
